// File: rtl/audio_pll_lock_ctrl.sv
// Audio PLL bring-up sequencer: holds the PLL in reset, waits for a stable lock,
// then releases the audio domain; retries on timeout and faults after MAX_RETRIES.
module audio_pll_lock_ctrl #(
    parameter int unsigned RST_HOLD_CYCLES     = 64,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       fault_clr,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       audio_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned CntMaxA = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CntMax  = (CntMaxA > LOCK_STABLE_CYCLES) ?
                                      CntMaxA : LOCK_STABLE_CYCLES;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle, StHoldRst, StWaitLock, StStable, StRun, StFault
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        retry_q, retry_d;
    logic [7:0]        loss_q, loss_d;
    logic              sync1_q, locked_s_q;
    logic              pll_rst_q, pll_rst_d;
    logic              audio_rst_n_q, audio_rst_n_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StHoldRst;
                    cnt_d   = '0;
                end
            end
            StHoldRst: begin
                if (cnt_q == CntW'(RST_HOLD_CYCLES - 1)) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitLock: begin
                if (locked_s_q) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    retry_d = retry_q + 4'd1;
                    cnt_d   = '0;
                    state_d = (retry_d == 4'(MAX_RETRIES)) ? StFault : StHoldRst;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStable: begin
                // The WAIT_LOCK cycle that saw lock counts as the first stable cycle.
                if (!locked_s_q) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(LOCK_STABLE_CYCLES - 2)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!locked_s_q) begin
                    state_d = StHoldRst;
                    cnt_d   = '0;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            StFault: begin
                if (fault_clr) begin
                    state_d = StIdle;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (!enable && state_q != StFault) begin
            state_d = StIdle;
            cnt_d   = '0;
            retry_d = retry_q;
            loss_d  = loss_q;
        end

        // Outputs are decoded from the next state so they register alongside it.
        pll_rst_d     = (state_d == StIdle) || (state_d == StHoldRst) || (state_d == StFault);
        audio_rst_n_d = (state_d == StRun);
        ready_d       = (state_d == StRun);
        fault_d       = (state_d == StFault);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            retry_q       <= '0;
            loss_q        <= '0;
            sync1_q       <= 1'b0;
            locked_s_q    <= 1'b0;
            pll_rst_q     <= 1'b1;
            audio_rst_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            loss_q        <= loss_d;
            sync1_q       <= pll_locked;
            locked_s_q    <= sync1_q;
            pll_rst_q     <= pll_rst_d;
            audio_rst_n_q <= audio_rst_n_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign audio_rst_n   = audio_rst_n_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_audio_pll_lock_ctrl.sv
// Directed bench for audio_pll_lock_ctrl with a behavioural PLL model and a
// scoreboard queue of expected values.
module tb_audio_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       fault_clr = 1'b0;
    logic       pll_locked;
    logic       pll_rst, audio_rst_n, ready, fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    // PLL model: locks as soon as it leaves reset unless told not to.
    logic lock_en = 1'b1;
    logic glitch  = 1'b0;
    assign pll_locked = lock_en & ~pll_rst & ~glitch;

    audio_pll_lock_ctrl #(
        .RST_HOLD_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .fault_clr    (fault_clr),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .audio_rst_n  (audio_rst_n),
        .ready        (ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic sb_push(input string tag, input int exp);
        sb_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_check(input int obs);
        sb_t it;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty: observed %0d with no expected value queued", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                n_err++;
                $error("FAIL %s: observed %0d expected %0d", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic expect_now(input string tag, input int exp, input int obs);
        sb_push(tag, exp);
        sb_check(obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_sig(input int which);
        case (which)
            0:       return pll_rst;
            1:       return audio_rst_n;
            2:       return ready;
            default: return fault;
        endcase
    endfunction

    // Ticks until the selected output reaches val; n = -1 if the bound expires.
    task automatic wait_for(input int which, input logic val, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (get_sig(which) !== val && n < limit);
        if (get_sig(which) !== val) n = -1;
    endtask

    task automatic check_reset_vals(input string pfx);
        expect_now({pfx, "_pll_rst"}, 1, int'(pll_rst));
        expect_now({pfx, "_audio_rst_n"}, 0, int'(audio_rst_n));
        expect_now({pfx, "_ready"}, 0, int'(ready));
        expect_now({pfx, "_fault"}, 0, int'(fault));
        expect_now({pfx, "_retry"}, 0, int'(retry_cnt));
        expect_now({pfx, "_loss"}, 0, int'(lock_loss_cnt));
    endtask

    initial begin
        int n;

        // Reset state
        #2 reset_n = 1'b0;
        #1 check_reset_vals("rst");
        #20 reset_n = 1'b1;
        repeat (3) tick();
        expect_now("no_auto_start_pll_rst", 1, int'(pll_rst));
        expect_now("no_auto_start_ready", 0, int'(ready));

        // Clean bring-up
        enable = 1'b1;
        sb_push("bringup_pll_rst_fall", 5);
        wait_for(0, 1'b0, 100, n);
        sb_check(n);
        sb_push("bringup_audio_rst_rise", 10);
        wait_for(1, 1'b1, 100, n);
        sb_check(n);
        expect_now("bringup_ready", 1, int'(ready));
        expect_now("bringup_retry", 0, int'(retry_cnt));
        expect_now("bringup_pll_rst", 0, int'(pll_rst));

        // Lock loss in RUN
        lock_en = 1'b0;
        sb_push("lossrun_audio_rst_fall", 3);
        wait_for(1, 1'b0, 100, n);
        sb_check(n);
        expect_now("lossrun_ready", 0, int'(ready));
        expect_now("lossrun_cnt", 1, int'(lock_loss_cnt));
        expect_now("lossrun_pll_rst", 1, int'(pll_rst));
        lock_en = 1'b1;
        sb_push("lossrun_pll_rst_width", 4);
        wait_for(0, 1'b0, 100, n);
        sb_check(n);
        sb_push("lossrun_relock", 10);
        wait_for(2, 1'b1, 100, n);
        sb_check(n);
        expect_now("lossrun_cnt_hold", 1, int'(lock_loss_cnt));

        // enable=0 from RUN, then lock glitch during STABLE
        enable = 1'b0;
        sb_push("disable_run_ready", 1);
        wait_for(2, 1'b0, 100, n);
        sb_check(n);
        enable = 1'b1;
        sb_push("glitch_pll_rst_fall", 5);
        wait_for(0, 1'b0, 100, n);
        sb_check(n);
        repeat (4) tick();
        glitch = 1'b1;
        tick();
        glitch = 1'b0;
        sb_push("glitch_run_delay", 10);
        wait_for(2, 1'b1, 100, n);
        sb_check(n);
        expect_now("glitch_retry", 0, int'(retry_cnt));

        // Lock never arrives: two timeouts then FAULT
        enable = 1'b0;
        tick();
        lock_en = 1'b0;
        enable  = 1'b1;
        sb_push("to_pll_rst_fall1", 5);
        wait_for(0, 1'b0, 100, n);
        sb_check(n);
        sb_push("to_window1", 20);
        wait_for(0, 1'b1, 100, n);
        sb_check(n);
        expect_now("to_retry1", 1, int'(retry_cnt));
        sb_push("to_hold2", 4);
        wait_for(0, 1'b0, 100, n);
        sb_check(n);
        sb_push("to_window2", 20);
        wait_for(3, 1'b1, 100, n);
        sb_check(n);
        expect_now("fault_retry2", 2, int'(retry_cnt));
        expect_now("fault_pll_rst", 1, int'(pll_rst));
        expect_now("fault_audio_rst_n", 0, int'(audio_rst_n));
        enable = 1'b0;
        repeat (3) tick();
        expect_now("fault_sticky_disable", 1, int'(fault));
        enable    = 1'b1;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        expect_now("clr_fault", 0, int'(fault));
        expect_now("clr_retry", 0, int'(retry_cnt));
        expect_now("clr_pll_rst", 1, int'(pll_rst));
        sb_push("clr_new_attempt", 5);
        wait_for(0, 1'b0, 100, n);
        sb_check(n);

        // enable drops on the very timeout edge
        repeat (19) tick();
        enable = 1'b0;
        tick();
        expect_now("disable_at_to_retry", 0, int'(retry_cnt));
        expect_now("disable_at_to_pll_rst", 1, int'(pll_rst));
        repeat (3) tick();
        expect_now("disable_at_to_idle_retry", 0, int'(retry_cnt));
        expect_now("disable_at_to_fault", 0, int'(fault));

        // Asynchronous reset during STABLE
        lock_en = 1'b1;
        enable  = 1'b1;
        sb_push("stable_pll_rst_fall", 5);
        wait_for(0, 1'b0, 100, n);
        sb_check(n);
        repeat (4) tick();
        reset_n = 1'b0;
        #1 check_reset_vals("midrst");
        #10 reset_n = 1'b1;
        repeat (2) tick();

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_leftover: observed %0d queued expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_pll_lock_ctrl.md
AUDIO_PLL_LOCK_CTRL -- requirements
Module: audio_pll_lock_ctrl

Interface
REQ-001 Parameter RST_HOLD_CYCLES, default 64: cycles pll_rst is held high per reset attempt (>=2).
REQ-002 Parameter LOCK_TIMEOUT_CYCLES, default 500000: cycles allowed in WAIT_LOCK before an attempt fails (>=4).
REQ-003 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized locked-high cycles required before release (>=2).
REQ-004 Parameter MAX_RETRIES, default 3: failed attempts tolerated before FAULT (1..15).
REQ-005 clk  input  1  free-running 50 MHz reference clock; all logic on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  level; 1 = bring the audio PLL up and keep it up, 0 = hold it in reset.
REQ-008 fault_clr  input  1  single-cycle pulse; leaves FAULT.
REQ-009 pll_locked  input  1  asynchronous lock indicator from the audio PLL.
REQ-010 pll_rst  output  1  active-high reset to the audio PLL.
REQ-011 audio_rst_n  output  1  active-low reset for logic clocked by the PLL output.
REQ-012 ready  output  1  high only in RUN.
REQ-013 fault  output  1  high only in FAULT.
REQ-014 retry_cnt  output  4  failed attempts since last RUN entry or fault_clr.
REQ-015 lock_loss_cnt  output  8  lock losses seen in RUN; saturates at 255.

Function
REQ-016 pll_locked SHALL pass through a 2-flop synchronizer (locked_s); no other logic SHALL sample pll_locked directly.
REQ-017 FSM states: IDLE, HOLD_RST, WAIT_LOCK, STABLE, RUN, FAULT; one state register, one shared down/up counter.
REQ-018 IDLE: pll_rst=1, audio_rst_n=0; enable=1 -> HOLD_RST with counter cleared.
REQ-019 HOLD_RST: pll_rst=1 for exactly RST_HOLD_CYCLES cycles, then -> WAIT_LOCK with counter cleared.
REQ-020 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE (counter cleared); counter reaching LOCK_TIMEOUT_CYCLES-1 with locked_s=0 -> attempt failed.
REQ-021 Attempt failed: retry_cnt increments; if new value equals MAX_RETRIES -> FAULT, else -> HOLD_RST.
REQ-022 STABLE: locked_s high for LOCK_STABLE_CYCLES consecutive cycles -> RUN; any locked_s=0 -> WAIT_LOCK with counter cleared (not counted as a failure).
REQ-023 RUN: pll_rst=0, audio_rst_n=1, ready=1; retry_cnt cleared on entry.
REQ-024 RUN with locked_s=0: audio_rst_n and ready SHALL drop on the next clock edge, lock_loss_cnt increments (saturating), -> HOLD_RST.
REQ-025 FAULT: pll_rst=1, audio_rst_n=0, fault=1; fault_clr=1 -> IDLE with retry_cnt cleared; otherwise remain.
REQ-026 enable=0 in any state except FAULT -> IDLE next cycle; enable=0 has priority over lock/timeout events in the same cycle.
REQ-027 In FAULT, fault_clr has priority over enable; enable=0 alone does not leave FAULT.
REQ-028 audio_rst_n SHALL be registered and SHALL rise only on the RUN entry edge; it is low in every non-RUN state.
REQ-029 Outputs SHALL be glitch-free registered signals; no combinational path from any input to any output.

Reset
REQ-030 reset_n=0 asynchronously forces IDLE, pll_rst=1, audio_rst_n=0, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, counter=0, synchronizer flops=0.
REQ-031 Reset release SHALL not by itself start an attempt; the first HOLD_RST entry requires enable=1 sampled after release.
REQ-032 reset_n asserted mid-attempt (any state) SHALL abandon the attempt with no retry_cnt change.

Verification (params RST_HOLD=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2)
REQ-033 enable=1, pll_locked tied 1 -> pll_rst high 4 cycles, audio_rst_n rises exactly 2(sync)+8 cycles after pll_rst falls, ready=1, retry_cnt=0.
REQ-034 pll_locked tied 0 -> two 20-cycle WAIT_LOCK windows, retry_cnt 1 then 2, fault=1, pll_rst=1; fault_clr pulse -> IDLE, retry_cnt=0, new attempt starts.
REQ-035 pll_locked glitches low for 1 cycle during STABLE -> returns to WAIT_LOCK, retry_cnt unchanged, RUN reached after a full 8-cycle stable run.
REQ-036 In RUN drop pll_locked -> audio_rst_n low 3 cycles later (2 sync + 1), lock_loss_cnt=1, pll_rst pulses 4 cycles, relock reaches RUN.
REQ-037 enable=0 in the same cycle the WAIT_LOCK timeout expires -> IDLE, retry_cnt unchanged; reset_n pulse in STABLE -> all outputs at REQ-030 values immediately.
